// File: rtl/id_fwd_hazard_unit_pkg.sv
// Shared definitions for the ID-stage forwarding / hazard unit.
// No logic of its own; consumers use it with zero added latency.
// Backpressure is not applicable here.
package id_fwd_hazard_unit_pkg;

   // Encoding of the per-source operand select.
   localparam logic [1:0] FWD_RF  = 2'd0;
   localparam logic [1:0] FWD_EX  = 2'd1;
   localparam logic [1:0] FWD_MEM = 2'd2;
   localparam logic [1:0] FWD_WB  = 2'd3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_STALL = 1'b1
   } fsm_state_t;

   // Larger of two stall-cycle requirements.
   function automatic logic [1:0] max_need(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/id_fwd_hazard_unit_if.sv
// Bundle of pipeline-state inputs and hazard/forwarding outputs of the ID stage.
// Purely wires; no latency.
// The stall output is the backpressure towards PC and IF/ID.
interface id_fwd_hazard_unit_if #(
   parameter int NUM_SRC = 2,
   parameter int REG_AW  = 5,
   parameter int CNT_W   = 16
);
   logic                      id_valid;
   logic                      id_is_branch;
   logic [NUM_SRC*REG_AW-1:0] id_src;
   logic [NUM_SRC-1:0]        id_src_used;
   logic [REG_AW-1:0]         ex_rd;
   logic [REG_AW-1:0]         mem_rd;
   logic [REG_AW-1:0]         wb_rd;
   logic                      ex_regwrite;
   logic                      mem_regwrite;
   logic                      wb_regwrite;
   logic                      ex_memread;
   logic                      mem_memread;
   logic                      flush;
   logic [2*NUM_SRC-1:0]      fwd_sel;
   logic                      stall;
   logic [CNT_W-1:0]          stall_cycles;

   modport master (
      output id_valid, id_is_branch, id_src, id_src_used,
      output ex_rd, mem_rd, wb_rd, ex_regwrite, mem_regwrite, wb_regwrite,
      output ex_memread, mem_memread, flush,
      input  fwd_sel, stall, stall_cycles
   );

   modport slave (
      input  id_valid, id_is_branch, id_src, id_src_used,
      input  ex_rd, mem_rd, wb_rd, ex_regwrite, mem_regwrite, wb_regwrite,
      input  ex_memread, mem_memread, flush,
      output fwd_sel, stall, stall_cycles
   );

endinterface

// File: rtl/id_fwd_hazard_unit_src_match.sv
// Per-source dependency check: stall cycles needed and forwarding select for one operand.
// Combinational, zero latency.
// No backpressure; the parent combines the need values into the stall.
module src_match
   import id_fwd_hazard_unit_pkg::*;
#(
   parameter int REG_AW       = 5,
   parameter bit FWD_EX_EN    = 1'b1,
   parameter bit WB_BYPASS_EN = 1'b1
) (
   input  logic [REG_AW-1:0] src,
   input  logic              used,
   input  logic              is_branch,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              ex_regwrite,
   input  logic              mem_regwrite,
   input  logic              wb_regwrite,
   input  logic              ex_memread,
   input  logic              mem_memread,
   output logic [1:0]        need,
   output logic [1:0]        sel
);

   // r0 is hardwired zero: a source of 0 never depends on anything, which
   // also excludes rd == 0 since the equality check requires rd == src.
   logic src_live;
   logic ex_hit, mem_hit, wb_hit;

   assign src_live = used && (src != '0);
   assign ex_hit   = src_live && ex_regwrite  && (ex_rd  == src);
   assign mem_hit  = src_live && mem_regwrite && (mem_rd == src);
   assign wb_hit   = src_live && wb_regwrite  && (wb_rd  == src);

   // Stall cycles required before this operand can be read or forwarded.
   always_comb begin
      need = 2'd0;
      if (is_branch) begin
         if (ex_hit && ex_memread)         need = 2'd2;
         else if (ex_hit && !FWD_EX_EN)    need = 2'd1;
         else if (mem_hit && mem_memread)  need = 2'd1;
      end else if (ex_hit && ex_memread) begin
         need = 2'd1;
      end
   end

   // Youngest producer wins; non-branch operands only see the WB bypass,
   // EX/MEM forwarding for them happens later in the EX stage.
   always_comb begin
      sel = FWD_RF;
      if (is_branch && ex_hit && FWD_EX_EN && !ex_memread)  sel = FWD_EX;
      else if (is_branch && mem_hit && !mem_memread)         sel = FWD_MEM;
      else if (wb_hit && WB_BYPASS_EN)                       sel = FWD_WB;
   end

endmodule

// File: rtl/id_fwd_hazard_unit.sv
// ID-stage operand forwarding select and load/branch hazard stall generation.
// Zero latency on stall/fwd_sel; stall_cycles updates on the clock edge.
// stall holds PC and IF/ID and injects a bubble; flush overrides any stall.
module id_fwd_hazard_unit
   import id_fwd_hazard_unit_pkg::*;
#(
   parameter int NUM_SRC      = 2,
   parameter int REG_AW       = 5,
   parameter bit FWD_EX_EN    = 1'b1,
   parameter bit WB_BYPASS_EN = 1'b1,
   parameter int CNT_W        = 16
) (
   input logic            clk,
   input logic            rst_n,
   id_fwd_hazard_unit_if.slave hif
);

   fsm_state_t                 state;
   logic [1:0]                 rem;
   logic [CNT_W-1:0]           cnt;
   logic [NUM_SRC-1:0][1:0]    need;
   logic [2*NUM_SRC-1:0]       sel_raw;
   logic [1:0]                 need_max;
   logic                       stall;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      src_match #(
         .REG_AW       (REG_AW),
         .FWD_EX_EN    (FWD_EX_EN),
         .WB_BYPASS_EN (WB_BYPASS_EN)
      ) u_src_match (
         .src          (hif.id_src[g*REG_AW +: REG_AW]),
         .used         (hif.id_src_used[g]),
         .is_branch    (hif.id_is_branch),
         .ex_rd        (hif.ex_rd),
         .mem_rd       (hif.mem_rd),
         .wb_rd        (hif.wb_rd),
         .ex_regwrite  (hif.ex_regwrite),
         .mem_regwrite (hif.mem_regwrite),
         .wb_regwrite  (hif.wb_regwrite),
         .ex_memread   (hif.ex_memread),
         .mem_memread  (hif.mem_memread),
         .need         (need[g]),
         .sel          (sel_raw[2*g +: 2])
      );
   end

   // Worst-case stall requirement across all sources.
   always_comb begin
      need_max = 2'd0;
      for (int i = 0; i < NUM_SRC; i++) begin
         need_max = max_need(need_max, need[i]);
      end
   end

   // Stall while sequencing a multi-cycle hazard or on a fresh hazard in IDLE.
   always_comb begin
      stall = 1'b0;
      if (!hif.flush) begin
         if (state == ST_STALL)                      stall = 1'b1;
         else if (hif.id_valid && need_max != 2'd0)  stall = 1'b1;
      end
   end

   assign hif.stall        = stall;
   assign hif.fwd_sel      = (stall || !hif.id_valid) ? '0 : sel_raw;
   assign hif.stall_cycles = cnt;

   // Two-cycle hazards park in STALL so the second cycle is not re-evaluated.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         rem   <= 2'd0;
      end else if (hif.flush) begin
         state <= ST_IDLE;
         rem   <= 2'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (hif.id_valid && need_max == 2'd2) begin
                  state <= ST_STALL;
                  rem   <= 2'd1;
               end
            end
            ST_STALL: begin
               rem <= rem - 2'd1;
               if (rem <= 2'd1) state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               rem   <= 2'd0;
            end
         endcase
      end
   end

   // Saturating count of stalled cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                               cnt <= '0;
      else if (stall && cnt != {CNT_W{1'b1}})   cnt <= cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_id_fwd_hazard_unit.sv
// Directed-vector bench for the ID forwarding/hazard unit.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
// A second instance is built with EX forwarding disabled.
module tb_id_fwd_hazard_unit;
   import id_fwd_hazard_unit_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   vectors     = 0;
   int   miscompares = 0;

   id_fwd_hazard_unit_if #(.NUM_SRC(2), .REG_AW(5), .CNT_W(16)) ifa ();
   id_fwd_hazard_unit_if #(.NUM_SRC(2), .REG_AW(5), .CNT_W(16)) ifb ();

   id_fwd_hazard_unit #(
      .NUM_SRC(2), .REG_AW(5), .FWD_EX_EN(1'b1), .WB_BYPASS_EN(1'b1), .CNT_W(16)
   ) dut_a (.clk(clk), .rst_n(rst_n), .hif(ifa));

   id_fwd_hazard_unit #(
      .NUM_SRC(2), .REG_AW(5), .FWD_EX_EN(1'b0), .WB_BYPASS_EN(1'b1), .CNT_W(16)
   ) dut_b (.clk(clk), .rst_n(rst_n), .hif(ifb));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ifa.id_valid = 0; ifa.id_is_branch = 0; ifa.id_src = '0; ifa.id_src_used = '0;
      ifa.ex_rd = '0; ifa.mem_rd = '0; ifa.wb_rd = '0;
      ifa.ex_regwrite = 0; ifa.mem_regwrite = 0; ifa.wb_regwrite = 0;
      ifa.ex_memread = 0; ifa.mem_memread = 0; ifa.flush = 0;
      ifb.id_valid = 0; ifb.id_is_branch = 0; ifb.id_src = '0; ifb.id_src_used = '0;
      ifb.ex_rd = '0; ifb.mem_rd = '0; ifb.wb_rd = '0;
      ifb.ex_regwrite = 0; ifb.mem_regwrite = 0; ifb.wb_regwrite = 0;
      ifb.ex_memread = 0; ifb.mem_memread = 0; ifb.flush = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      clear_inputs();
      // Invalid instruction with a WB match must still select the regfile.
      ifa.id_is_branch = 1; ifa.id_src = {5'd0, 5'd3}; ifa.id_src_used = 2'b01;
      ifa.wb_rd = 5'd3; ifa.wb_regwrite = 1;
      tick(); tick();
      vectors++; if (ifa.stall_cycles !== 16'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d want 0", ifa.stall_cycles); end
      vectors++; if (ifa.stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b want 0", ifa.stall); end
      vectors++; if (ifa.fwd_sel !== 4'b0000) begin miscompares++; $display("FAIL reset_fwd_invalid: got %b want 0000", ifa.fwd_sel); end
      vectors++; if (ifb.stall_cycles !== 16'd0) begin miscompares++; $display("FAIL reset_cnt_b: got %0d want 0", ifb.stall_cycles); end
      rst_n = 1;
      tick();
   endtask

   task automatic test_load_branch();
      clear_inputs();
      ifa.id_valid = 1; ifa.id_is_branch = 1; ifa.id_src = {5'd0, 5'd5}; ifa.id_src_used = 2'b01;
      ifa.ex_rd = 5'd5; ifa.ex_regwrite = 1; ifa.ex_memread = 1;
      #1;
      vectors++; if (ifa.stall !== 1'b1) begin miscompares++; $display("FAIL ldbr_stall_c1: got %b want 1", ifa.stall); end
      vectors++; if (ifa.fwd_sel !== 4'b0000) begin miscompares++; $display("FAIL ldbr_fwd_c1: got %b want 0000", ifa.fwd_sel); end
      tick();
      // Load moved to MEM, bubble in EX; STALL holds regardless.
      ifa.ex_rd = '0; ifa.ex_regwrite = 0; ifa.ex_memread = 0;
      ifa.mem_rd = 5'd5; ifa.mem_regwrite = 1; ifa.mem_memread = 1;
      #1;
      vectors++; if (ifa.stall !== 1'b1) begin miscompares++; $display("FAIL ldbr_stall_c2: got %b want 1", ifa.stall); end
      vectors++; if (ifa.stall_cycles !== 16'd1) begin miscompares++; $display("FAIL ldbr_cnt_c2: got %0d want 1", ifa.stall_cycles); end
      tick();
      ifa.mem_memread = 0;
      #1;
      vectors++; if (ifa.stall !== 1'b0) begin miscompares++; $display("FAIL ldbr_stall_c3: got %b want 0", ifa.stall); end
      vectors++; if (ifa.fwd_sel !== 4'b0010) begin miscompares++; $display("FAIL ldbr_fwd_mem: got %b want 0010", ifa.fwd_sel); end
      vectors++; if (ifa.stall_cycles !== 16'd2) begin miscompares++; $display("FAIL ldbr_cnt: got %0d want 2", ifa.stall_cycles); end
   endtask

   task automatic test_alu_branch();
      clear_inputs();
      tick();
      ifa.id_valid = 1; ifa.id_is_branch = 1; ifa.id_src = {5'd7, 5'd0}; ifa.id_src_used = 2'b10;
      ifa.ex_rd = 5'd7; ifa.ex_regwrite = 1;
      ifb.id_valid = 1; ifb.id_is_branch = 1; ifb.id_src = {5'd7, 5'd0}; ifb.id_src_used = 2'b10;
      ifb.ex_rd = 5'd7; ifb.ex_regwrite = 1;
      #1;
      vectors++; if (ifa.stall !== 1'b0) begin miscompares++; $display("FAIL alubr_a_stall: got %b want 0", ifa.stall); end
      vectors++; if (ifa.fwd_sel !== 4'b0100) begin miscompares++; $display("FAIL alubr_a_fwd: got %b want 0100", ifa.fwd_sel); end
      vectors++; if (ifb.stall !== 1'b1) begin miscompares++; $display("FAIL alubr_b_stall: got %b want 1", ifb.stall); end
      vectors++; if (ifb.fwd_sel !== 4'b0000) begin miscompares++; $display("FAIL alubr_b_fwd_stalled: got %b want 0000", ifb.fwd_sel); end
      tick();
      ifb.ex_rd = '0; ifb.ex_regwrite = 0; ifb.mem_rd = 5'd7; ifb.mem_regwrite = 1;
      #1;
      vectors++; if (ifb.stall !== 1'b0) begin miscompares++; $display("FAIL alubr_b_stall_after: got %b want 0", ifb.stall); end
      vectors++; if (ifb.fwd_sel !== 4'b1000) begin miscompares++; $display("FAIL alubr_b_fwd_mem: got %b want 1000", ifb.fwd_sel); end
      vectors++; if (ifb.stall_cycles !== 16'd1) begin miscompares++; $display("FAIL alubr_b_cnt: got %0d want 1", ifb.stall_cycles); end
      vectors++; if (ifa.stall_cycles !== 16'd2) begin miscompares++; $display("FAIL alubr_a_cnt: got %0d want 2", ifa.stall_cycles); end
   endtask

   task automatic test_priority();
      clear_inputs();
      tick();
      ifa.id_valid = 1; ifa.id_is_branch = 1; ifa.id_src = {5'd0, 5'd3}; ifa.id_src_used = 2'b01;
      ifa.ex_rd = 5'd3; ifa.mem_rd = 5'd3; ifa.wb_rd = 5'd3;
      ifa.ex_regwrite = 1; ifa.mem_regwrite = 1; ifa.wb_regwrite = 1;
      #1;
      vectors++; if (ifa.fwd_sel !== 4'b0001) begin miscompares++; $display("FAIL prio_ex: got %b want 0001", ifa.fwd_sel); end
      vectors++; if (ifa.stall !== 1'b0) begin miscompares++; $display("FAIL prio_stall: got %b want 0", ifa.stall); end
      ifa.ex_regwrite = 0; #1;
      vectors++; if (ifa.fwd_sel !== 4'b0010) begin miscompares++; $display("FAIL prio_mem: got %b want 0010", ifa.fwd_sel); end
      ifa.mem_regwrite = 0; #1;
      vectors++; if (ifa.fwd_sel !== 4'b0011) begin miscompares++; $display("FAIL prio_wb: got %b want 0011", ifa.fwd_sel); end
      // Register 0 never forwards or stalls, even against a load.
      ifa.id_src = '0; ifa.id_src_used = 2'b11; ifa.ex_rd = '0; ifa.mem_rd = '0; ifa.wb_rd = '0;
      ifa.ex_regwrite = 1; ifa.mem_regwrite = 1; ifa.ex_memread = 1; ifa.mem_memread = 1;
      #1;
      vectors++; if (ifa.fwd_sel !== 4'b0000) begin miscompares++; $display("FAIL r0_fwd: got %b want 0000", ifa.fwd_sel); end
      vectors++; if (ifa.stall !== 1'b0) begin miscompares++; $display("FAIL r0_stall: got %b want 0", ifa.stall); end
      // Non-branch: EX/MEM matches are ignored, only WB bypass applies.
      ifa.id_is_branch = 0; ifa.id_src = {5'd9, 5'd3};
      ifa.ex_rd = 5'd3; ifa.ex_memread = 0; ifa.mem_rd = 5'd9; ifa.mem_memread = 0; ifa.wb_rd = 5'd9;
      #1;
      vectors++; if (ifa.fwd_sel !== 4'b1100) begin miscompares++; $display("FAIL nonbr_fwd: got %b want 1100", ifa.fwd_sel); end
      vectors++; if (ifa.stall !== 1'b0) begin miscompares++; $display("FAIL nonbr_stall: got %b want 0", ifa.stall); end
   endtask

   task automatic test_load_use_flush();
      clear_inputs();
      tick();
      ifa.id_valid = 1; ifa.id_src = {5'd0, 5'd4}; ifa.id_src_used = 2'b01;
      ifa.ex_rd = 5'd4; ifa.ex_regwrite = 1; ifa.ex_memread = 1;
      #1;
      vectors++; if (ifa.stall !== 1'b1) begin miscompares++; $display("FAIL lduse_stall: got %b want 1", ifa.stall); end
      tick();
      ifa.ex_rd = '0; ifa.ex_regwrite = 0; ifa.ex_memread = 0;
      ifa.mem_rd = 5'd4; ifa.mem_regwrite = 1; ifa.mem_memread = 1;
      #1;
      vectors++; if (ifa.stall !== 1'b0) begin miscompares++; $display("FAIL lduse_release: got %b want 0", ifa.stall); end
      vectors++; if (ifa.stall_cycles !== 16'd3) begin miscompares++; $display("FAIL lduse_cnt: got %0d want 3", ifa.stall_cycles); end
      // Flush on the second cycle of a two-cycle stall.
      clear_inputs();
      tick();
      ifa.id_valid = 1; ifa.id_is_branch = 1; ifa.id_src = {5'd0, 5'd6}; ifa.id_src_used = 2'b01;
      ifa.ex_rd = 5'd6; ifa.ex_regwrite = 1; ifa.ex_memread = 1;
      #1;
      vectors++; if (ifa.stall !== 1'b1) begin miscompares++; $display("FAIL flush_pre: got %b want 1", ifa.stall); end
      tick();
      ifa.flush = 1;
      #1;
      vectors++; if (ifa.stall !== 1'b0) begin miscompares++; $display("FAIL flush_drop: got %b want 0", ifa.stall); end
      tick();
      ifa.flush = 0; ifa.ex_regwrite = 0; ifa.ex_memread = 0;
      #1;
      vectors++; if (ifa.stall !== 1'b0) begin miscompares++; $display("FAIL flush_idle: got %b want 0", ifa.stall); end
      vectors++; if (ifa.stall_cycles !== 16'd4) begin miscompares++; $display("FAIL flush_cnt: got %0d want 4", ifa.stall_cycles); end
      // Flush in IDLE must keep the FSM from entering STALL.
      ifa.ex_regwrite = 1; ifa.ex_memread = 1; ifa.flush = 1;
      #1;
      vectors++; if (ifa.stall !== 1'b0) begin miscompares++; $display("FAIL flush_idle_override: got %b want 0", ifa.stall); end
      tick();
      ifa.flush = 0; ifa.ex_regwrite = 0; ifa.ex_memread = 0;
      #1;
      vectors++; if (ifa.stall !== 1'b0) begin miscompares++; $display("FAIL flush_no_stall_state: got %b want 0", ifa.stall); end
      vectors++; if (ifa.stall_cycles !== 16'd4) begin miscompares++; $display("FAIL flush_cnt2: got %0d want 4", ifa.stall_cycles); end
   endtask

   task automatic test_reset_mid_stall();
      clear_inputs();
      tick();
      ifa.id_valid = 1; ifa.id_is_branch = 1; ifa.id_src = {5'd0, 5'd8}; ifa.id_src_used = 2'b01;
      ifa.ex_rd = 5'd8; ifa.ex_regwrite = 1; ifa.ex_memread = 1;
      tick();
      #1;
      vectors++; if (ifa.stall !== 1'b1) begin miscompares++; $display("FAIL rst_mid_in_stall: got %b want 1", ifa.stall); end
      rst_n = 0;
      #1;
      vectors++; if (ifa.stall_cycles !== 16'd0) begin miscompares++; $display("FAIL rst_mid_cnt: got %0d want 0", ifa.stall_cycles); end
      clear_inputs();
      ifa.id_valid = 1;
      rst_n = 1;
      #1;
      vectors++; if (ifa.stall !== 1'b0) begin miscompares++; $display("FAIL rst_mid_idle: got %b want 0", ifa.stall); end
      tick();
      vectors++; if (ifa.stall_cycles !== 16'd0) begin miscompares++; $display("FAIL rst_mid_cnt_after: got %0d want 0", ifa.stall_cycles); end
      ifa.id_src = {5'd0, 5'd4}; ifa.id_src_used = 2'b01;
      ifa.ex_rd = 5'd4; ifa.ex_regwrite = 1; ifa.ex_memread = 1;
      #1;
      vectors++; if (ifa.stall !== 1'b1) begin miscompares++; $display("FAIL rst_mid_reeval: got %b want 1", ifa.stall); end
   endtask

   task automatic test_saturation();
      // Load-use hazard held constant: stall every cycle.
      repeat (100) @(posedge clk);
      #1;
      vectors++; if (ifa.stall_cycles !== 16'd100) begin miscompares++; $display("FAIL sat_cnt100: got %0d want 100", ifa.stall_cycles); end
      repeat (69900) @(posedge clk);
      #1;
      vectors++; if (ifa.stall_cycles !== 16'hFFFF) begin miscompares++; $display("FAIL sat_cnt_max: got %0d want 65535", ifa.stall_cycles); end
      vectors++; if (ifa.stall !== 1'b1) begin miscompares++; $display("FAIL sat_stall: got %b want 1", ifa.stall); end
   endtask

   initial begin
      test_reset();
      test_load_branch();
      test_alu_branch();
      test_priority();
      test_load_use_flush();
      test_reset_mid_stall();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/id_fwd_hazard_unit.md
ID_FWD_HAZARD_UNIT -- requirements
Module: id_fwd_hazard_unit

Interface
REQ-001 Parameter NUM_SRC, default 2, number of ID-stage source operands checked.
REQ-002 Parameter REG_AW, default 5, register-address width.
REQ-003 Parameter FWD_EX_EN, default 1, 1 = ALU result in EX may forward to ID; 0 = such a match stalls 1 cycle.
REQ-004 Parameter WB_BYPASS_EN, default 1, 1 = WB-stage result forwarded; 0 = register file write-before-read covers WB.
REQ-005 Parameter CNT_W, default 16, width of stall statistics counter.
REQ-006 Port list:
  clk  input  1  sole clock, rising edge
  rst_n  input  1  asynchronous active-low reset
  id_valid  input  1  valid instruction in IF/ID
  id_is_branch  input  1  ID instruction resolves branch in ID, needs operands this cycle
  id_src  input  NUM_SRC*REG_AW  packed source register numbers, src0 in LSBs
  id_src_used  input  NUM_SRC  per-source use mask
  ex_rd, mem_rd, wb_rd  input  REG_AW each  destination registers in ID/EX, EX/MEM, MEM/WB
  ex_regwrite, mem_regwrite, wb_regwrite  input  1 each  stage writes register
  ex_memread, mem_memread  input  1 each  stage holds a load
  flush  input  1  ID instruction squashed (taken branch / exception)
  fwd_sel  output  2*NUM_SRC  per-source select: 0 regfile, 1 EX, 2 MEM, 3 WB
  stall  output  1  hold PC and IF/ID, inject bubble into ID/EX
  stall_cycles  output  CNT_W  saturating count of stalled cycles

Function
REQ-007 A stage "matches" source i when id_src_used[i]=1, stage regwrite=1, stage rd = id_src[i], and stage rd != 0.
REQ-008 Required stall count N (IDLE only, id_valid=1): branch with EX-match and ex_memread -> 2; branch with EX-match, no memread, FWD_EX_EN=0 -> 1; branch with MEM-match and mem_memread -> 1; non-branch with EX-match and ex_memread -> 1; else 0; N is the maximum over all sources.
REQ-009 FSM states IDLE and STALL; counter rem of 2 bits.
REQ-010 IDLE, N=0: stall=0, stay IDLE.
REQ-011 IDLE, N=1: stall=1 this cycle, stay IDLE (re-evaluate next cycle).
REQ-012 IDLE, N=2: stall=1 this cycle, rem<=1, go STALL.
REQ-013 STALL: stall=1; rem decrements; when rem=1 at clock edge, go IDLE; total stall = N cycles, no re-evaluation in STALL.
REQ-014 flush=1 in any state: stall=0 combinationally, next state IDLE, rem<=0; flush overrides hazard.
REQ-015 id_valid=0 in IDLE: stall=0, fwd_sel=0.
REQ-016 fwd_sel per source, valid only when stall=0 (forced 0 while stall=1): priority EX (only if branch, FWD_EX_EN=1, ex_memread=0) > MEM (only if branch, mem_memread=0) > WB (only if WB_BYPASS_EN=1) > 0; non-branch sources select only WB or 0.
REQ-017 Source numbered 0 always selects 0 and never causes a stall.
REQ-018 stall_cycles increments by 1 on each edge where stall=1, saturating at 2^CNT_W-1.
REQ-019 Outputs stall and fwd_sel are combinational from inputs and state; zero latency.

Reset
REQ-020 rst_n=0 asynchronously forces state IDLE, rem=0, stall_cycles=0; stall and fwd_sel then follow REQ-010..016 from IDLE.
REQ-021 Reset asserted mid-STALL aborts the stall sequence; first cycle after deassertion re-evaluates from IDLE.

Structure
REQ-022 Shared package holds fwd_sel encoding constants (FWD_RF, FWD_EX, FWD_MEM, FWD_WB) and FSM state typedef.
REQ-023 One sub-module src_match, instantiated NUM_SRC times, producing per-source match flags, N contribution, and fwd_sel.

Verification
REQ-024 Branch src0=r5, ex_rd=5, ex_regwrite=1, ex_memread=1 -> stall=1 exactly 2 cycles (IDLE, STALL), then fwd_sel=2 when load reaches MEM with mem_memread=0.
REQ-025 Branch src1=r7, ex_rd=7 ALU op, FWD_EX_EN=1 -> stall=0, fwd_sel[3:2]=1; with FWD_EX_EN=0 -> 1 stall cycle then fwd_sel[3:2]=2.
REQ-026 Branch src0=r3 matching ex_rd=3, mem_rd=3, wb_rd=3 all regwrite, no loads -> fwd_sel[1:0]=1 (priority); ex_rd=0 and src0=0 variant -> fwd_sel=0, no stall.
REQ-027 Non-branch load-use (ex_memread=1, ex_rd=4, src0=4) -> 1 stall cycle; flush asserted during second cycle of a 2-cycle stall -> stall drops same cycle, state IDLE.
REQ-028 rst_n pulsed low mid-STALL -> stall_cycles=0, state IDLE; 70000 forced stall cycles with CNT_W=16 -> stall_cycles holds 65535.
